led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_pkg.sv | 13 +
 rtl/led_channel.sv | 109 ++++++++++
 rtl/led_pattern_gen.sv | 56 +++++
 tb/tb_led_pattern_gen.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        ModeOff     = 2'd0,
        ModeOn      = 2'd1,
        ModeBlink   = 2'd2,
        ModeBreathe = 2'd3
    } mode_e;

    localparam int unsigned HalfPeriodW = 16;

endpackage

// File: rtl/led_channel.sv
// One LED channel: registered mode, blink counter/state, breathe duty ramp and
// the registered LED drive.
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int unsigned PwmBits = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   tick_i,
    input  logic [PwmBits-1:0]     pwm_cnt_i,
    input  logic [1:0]             mode_i,
    input  logic [HalfPeriodW-1:0] half_period_i,
    output logic                   led_o
);

    localparam logic [PwmBits-1:0] DutyMax = '1;

    mode_e                  mode_in;
    mode_e                  mode_q;
    logic [HalfPeriodW-1:0] cnt_q, cnt_d;
    logic [HalfPeriodW-1:0] limit;
    logic                   blink_q, blink_d;
    logic [PwmBits-1:0]     duty_q, duty_d;
    logic                   up_q, up_d;
    logic                   led_q, led_d;

    assign mode_in = mode_e'(mode_i);

    // A half-period of 0 is treated as 1, i.e. toggle on every tick.
    assign limit = (half_period_i == '0) ? '0 : half_period_i - HalfPeriodW'(1);

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        duty_d  = duty_q;
        up_d    = up_q;

        // A mode change wins over a coincident tick.
        if (mode_in != mode_q) begin
            cnt_d   = '0;
            blink_d = 1'b0;
            duty_d  = '0;
            up_d    = 1'b1;
        end else if (tick_i) begin
            case (mode_q)
                ModeBlink: begin
                    if (cnt_q >= limit) begin
                        cnt_d   = '0;
                        blink_d = ~blink_q;
                    end else begin
                        cnt_d = cnt_q + HalfPeriodW'(1);
                    end
                end
                ModeBreathe: begin
                    // Turn around at each extreme so the peak and floor last one tick.
                    if (up_q) begin
                        if (duty_q == DutyMax) begin
                            duty_d = duty_q - PwmBits'(1);
                            up_d   = 1'b0;
                        end else begin
                            duty_d = duty_q + PwmBits'(1);
                        end
                    end else begin
                        if (duty_q == '0) begin
                            duty_d = duty_q + PwmBits'(1);
                            up_d   = 1'b1;
                        end else begin
                            duty_d = duty_q - PwmBits'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            ModeOff:     led_d = 1'b0;
            ModeOn:      led_d = 1'b1;
            ModeBlink:   led_d = blink_q;
            ModeBreathe: led_d = (pwm_cnt_i < duty_q);
            default:     led_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q  <= ModeOff;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            duty_q  <= '0;
            up_q    <= 1'b1;
            led_q   <= 1'b0;
        end else begin
            mode_q  <= mode_in;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            duty_q  <= duty_d;
            up_q    <= up_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler and PWM counter
// feeding NUM_CH independent channels.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [2*NUM_CH-1:0]           mode,
    input  logic [HalfPeriodW*NUM_CH-1:0] half_period,
    output logic [NUM_CH-1:0]             led
);

    localparam int unsigned Div  = CLK_FREQ / TICK_HZ;
    localparam int unsigned PreW = $clog2(Div);
    localparam logic [PreW-1:0] PreMax = PreW'(Div - 1);

    if (Div < 2) begin : g_bad_div
        $error("CLK_FREQ/TICK_HZ must be at least 2");
    end

    logic [PreW-1:0]     pre_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic                tick;

    assign tick = (pre_q == PreMax);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q <= '0;
            pwm_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PreW'(1);
            pwm_q <= pwm_q + PWM_BITS'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_channel #(
            .PwmBits(PWM_BITS)
        ) u_ch (
            .CLK          (CLK),
            .RST          (RST),
            .tick_i       (tick),
            .pwm_cnt_i    (pwm_q),
            .mode_i       (mode[2*i +: 2]),
            .half_period_i(half_period[HalfPeriodW*i +: HalfPeriodW]),
            .led_o        (led[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised and directed bench for led_pattern_gen against a closed-form model.
module tb_led_pattern_gen;

    localparam int NCH  = 2;
    localparam int DIV  = 10;
    localparam int PWM  = 16;
    localparam int TRI  = 30;
    localparam int MOff = 0, MOn = 1, MBlink = 2, MBreathe = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  mode = '0;
    logic [31:0] half_period = '0;
    logic [1:0]  led;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: each channel's current and previous pattern segment (mode, hp, start edge).
    int cur_mode[NCH], cur_hp[NCH], cur_start[NCH];
    int prev_mode[NCH], prev_hp[NCH], prev_start[NCH];

    led_pattern_gen #(
        .CLK_FREQ(100),
        .TICK_HZ (10),
        .NUM_CH  (2),
        .PWM_BITS(4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .mode       (mode),
        .half_period(half_period),
        .led        (led)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Expected led after edge e: ticks happen on edges that are multiples of DIV,
    // a segment's own start edge never counts, and led lags state by one edge.
    function automatic bit exp_led(int ch, int e);
        int m, hp, s, k, ph, d;
        if (e > cur_start[ch]) begin
            m = cur_mode[ch]; hp = cur_hp[ch]; s = cur_start[ch];
        end else begin
            m = prev_mode[ch]; hp = prev_hp[ch]; s = prev_start[ch];
        end
        if (e == 0) return 1'b0;
        k = (e - 1) / DIV - s / DIV;
        case (m)
            MOff: return 1'b0;
            MOn:  return 1'b1;
            MBlink: begin
                if (hp == 0) hp = 1;
                return ((k / hp) % 2) == 1;
            end
            default: begin
                ph = k % TRI;
                d  = (ph <= 15) ? ph : TRI - ph;
                return ((e - 1) % PWM) < d;
            end
        endcase
    endfunction

    task automatic set_ch(input int ch, input int m, input int hp);
        if (m != cur_mode[ch]) begin
            mode[2*ch +: 2]         = 2'(m);
            half_period[16*ch +: 16] = 16'(hp);
            prev_mode[ch]  = cur_mode[ch];
            prev_hp[ch]    = cur_hp[ch];
            prev_start[ch] = cur_start[ch];
            cur_mode[ch]   = m;
            cur_hp[ch]     = hp;
            cur_start[ch]  = cyc + 1;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            prev_mode[c] = MOff; prev_hp[c] = 0; prev_start[c] = 0;
            cur_mode[c]  = int'(mode[2*c +: 2]);
            cur_hp[c]    = int'(half_period[16*c +: 16]);
            cur_start[c] = (cur_mode[c] != MOff) ? 1 : 0;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        model_reset();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        #1 RST = 1'b1;
        #1;
        tests++;
        if (led !== 2'b00) begin
            fails++; $display("FAIL reset_async: led=%b required 00", led);
        end
        repeat (2) @(negedge CLK);
        tests++;
        if (led !== 2'b00) begin
            fails++; $display("FAIL reset_hold: led=%b required 00", led);
        end
        model_reset();
        RST = 1'b0;
        repeat (15) begin
            @(negedge CLK);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (led[c] !== exp_led(c, cyc)) begin
                    fails++; $display("FAIL reset_idle ch%0d cyc %0d: led=%b required %b",
                                      c, cyc, led[c], exp_led(c, cyc));
                end
            end
        end
    endtask

    task automatic test_on_off();
        int e0;
        set_ch(0, MOn, 0);
        e0 = cyc + 1;
        repeat (12) begin
            @(negedge CLK);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (led[c] !== exp_led(c, cyc)) begin
                    fails++; $display("FAIL on ch%0d cyc %0d: led=%b required %b",
                                      c, cyc, led[c], exp_led(c, cyc));
                end
            end
            if (cyc == e0) begin
                tests++;
                if (led[0] !== 1'b0) begin
                    fails++; $display("FAIL on_latency_early: led0=%b required 0", led[0]);
                end
            end
        end
        set_ch(0, MOff, 0);
        repeat (6) begin
            @(negedge CLK);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (led[c] !== exp_led(c, cyc)) begin
                    fails++; $display("FAIL off ch%0d cyc %0d: led=%b required %b",
                                      c, cyc, led[c], exp_led(c, cyc));
                end
            end
        end
    endtask

    task automatic test_blink();
        int e0, t3;
        set_ch(0, MBlink, 3);
        e0 = cyc + 1;
        t3 = (e0 / DIV + 1) * DIV + 2 * DIV;
        repeat (110) begin
            @(negedge CLK);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (led[c] !== exp_led(c, cyc)) begin
                    fails++; $display("FAIL blink ch%0d cyc %0d: led=%b required %b",
                                      c, cyc, led[c], exp_led(c, cyc));
                end
            end
            if (cyc == t3 || cyc == t3 + 31) begin
                tests++;
                if (led[0] !== 1'b0) begin
                    fails++; $display("FAIL blink_edge cyc %0d: led0=%b required 0", cyc, led[0]);
                end
            end
            if (cyc == t3 + 1 || cyc == t3 + 30) begin
                tests++;
                if (led[0] !== 1'b1) begin
                    fails++; $display("FAIL blink_edge cyc %0d: led0=%b required 1", cyc, led[0]);
                end
            end
        end
    endtask

    task automatic test_blink_hp0();
        int  e0;
        logic prev1;
        set_ch(0, MOn, 0);
        set_ch(1, MBlink, 0);
        e0 = cyc + 1;
        prev1 = led[1];
        repeat (60) begin
            @(negedge CLK);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (led[c] !== exp_led(c, cyc)) begin
                    fails++; $display("FAIL blink_hp0 ch%0d cyc %0d: led=%b required %b",
                                      c, cyc, led[c], exp_led(c, cyc));
                end
            end
            if (cyc == e0 + 1) begin
                tests++;
                if (led[0] !== 1'b1) begin
                    fails++; $display("FAIL on_latency: led0=%b required 1", led[0]);
                end
            end
            if (cyc >= e0 + 3) begin
                tests++;
                if ((led[1] != prev1) !== (cyc % DIV == 1)) begin
                    fails++; $display("FAIL blink_hp0_toggle cyc %0d: changed=%b required %b",
                                      cyc, led[1] != prev1, cyc % DIV == 1);
                end
            end
            prev1 = led[1];
        end
    endtask

    task automatic test_breathe();
        set_ch(1, MOff, 0);
        set_ch(0, MBreathe, 0);
        repeat (650) begin
            @(negedge CLK);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (led[c] !== exp_led(c, cyc)) begin
                    fails++; $display("FAIL breathe ch%0d cyc %0d: led=%b required %b",
                                      c, cyc, led[c], exp_led(c, cyc));
                end
            end
        end
    endtask

    task automatic test_mode_change_on_tick();
        int e2;
        set_ch(0, MBlink, 3);
        repeat (45) begin
            @(negedge CLK);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (led[c] !== exp_led(c, cyc)) begin
                    fails++; $display("FAIL tickchg_pre ch%0d cyc %0d: led=%b required %b",
                                      c, cyc, led[c], exp_led(c, cyc));
                end
            end
        end
        for (int i = 0; i < 12 && (cyc % DIV) != 8; i++) @(negedge CLK);
        tests++;
        if ((cyc % DIV) != 8) begin
            fails++; $display("FAIL tickchg_align: cyc mod 10=%0d required 8", cyc % DIV);
        end
        set_ch(0, MOff, 0);
        @(negedge CLK);
        set_ch(0, MBlink, 3);
        e2 = cyc + 1;
        repeat (70) begin
            @(negedge CLK);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (led[c] !== exp_led(c, cyc)) begin
                    fails++; $display("FAIL tickchg ch%0d cyc %0d: led=%b required %b",
                                      c, cyc, led[c], exp_led(c, cyc));
                end
            end
            if (cyc == e2 + 30 || cyc == e2 + 31) begin
                tests++;
                if (led[0] !== (cyc == e2 + 31)) begin
                    fails++; $display("FAIL tickchg_restart cyc %0d: led0=%b required %b",
                                      cyc, led[0], cyc == e2 + 31);
                end
            end
        end
    endtask

    task automatic test_hp_change();
        int e0, t3;
        set_ch(0, MOff, 0);
        repeat (5) @(negedge CLK);
        set_ch(0, MBlink, 5);
        e0 = cyc + 1;
        t3 = (e0 / DIV + 1) * DIV + 2 * DIV;
        repeat (80) begin
            @(negedge CLK);
            tests++;
            if (led[1] !== exp_led(1, cyc)) begin
                fails++; $display("FAIL hpchg ch1 cyc %0d: led=%b required %b",
                                  cyc, led[1], exp_led(1, cyc));
            end
            if (cyc == t3) half_period[15:0] = 16'd2;
            if (cyc == t3 + 10 || cyc == t3 + 31) begin
                tests++;
                if (led[0] !== 1'b0) begin
                    fails++; $display("FAIL hpchg cyc %0d: led0=%b required 0", cyc, led[0]);
                end
            end
            if (cyc == t3 + 11 || cyc == t3 + 30) begin
                tests++;
                if (led[0] !== 1'b1) begin
                    fails++; $display("FAIL hpchg cyc %0d: led0=%b required 1", cyc, led[0]);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_random();
        repeat (12) begin
            for (int c = 0; c < NCH; c++) begin
                set_ch(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            end
            repeat ($urandom_range(5, 120)) begin
                @(negedge CLK);
                for (int c = 0; c < NCH; c++) begin
                    tests++;
                    if (led[c] !== exp_led(c, cyc)) begin
                        fails++; $display("FAIL random ch%0d cyc %0d: led=%b required %b",
                                          c, cyc, led[c], exp_led(c, cyc));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        set_ch(0, MOn, 0);
        set_ch(1, MBlink, 0);
        repeat (40) @(negedge CLK);
        tests++;
        if (led[0] !== 1'b1) begin
            fails++; $display("FAIL midrst_pre: led0=%b required 1", led[0]);
        end
        #2 RST = 1'b1;
        #1;
        tests++;
        if (led !== 2'b00) begin
            fails++; $display("FAIL midrst_async: led=%b required 00", led);
        end
        repeat (3) @(negedge CLK);
        model_reset();
        RST = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (led[c] !== exp_led(c, cyc)) begin
                    fails++; $display("FAIL midrst ch%0d cyc %0d: led=%b required %b",
                                      c, cyc, led[c], exp_led(c, cyc));
                end
            end
            if (cyc == 1 || cyc == 2) begin
                tests++;
                if (led[0] !== (cyc == 2)) begin
                    fails++; $display("FAIL midrst_on cyc %0d: led0=%b required %b",
                                      cyc, led[0], cyc == 2);
                end
            end
            if (cyc == 10 || cyc == 11) begin
                tests++;
                if (led[1] !== (cyc == 11)) begin
                    fails++; $display("FAIL midrst_first_tick cyc %0d: led1=%b required %b",
                                      cyc, led[1], cyc == 11);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_on_off();
        test_blink();
        test_blink_hp0();
        test_breathe();
        test_mode_change_on_tick();
        test_hp_change();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
